// File: rtl/uart_rx_mmio_pkg.sv
// Shared definitions for the memory-mapped UART receiver.
// Register offsets, STATUS bit positions and receiver FSM states.
package uart_pkg;

  localparam logic [3:0] UART_DATA_OFS   = 4'h0;
  localparam logic [3:0] UART_STATUS_OFS = 4'h4;
  localparam logic [3:0] UART_CTRL_OFS   = 4'h8;

  localparam int ST_NEMPTY = 0;
  localparam int ST_FULL   = 1;
  localparam int ST_OE     = 2;
  localparam int ST_FE     = 3;
  localparam int ST_PE     = 4;
  localparam int ST_CNT    = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_e;

endpackage

// File: rtl/uart_rx_mmio_if.sv
// Register access bus between the memory stage and the UART receiver.
// The memory stage is the master; the UART register block is the slave.
interface uart_rx_mmio_if;
  logic        RD_EN;
  logic        WR_EN;
  logic [3:0]  ADDR;
  logic [63:0] WR_DATA;
  logic [63:0] RD_DATA;

  modport master (
    output RD_EN, WR_EN, ADDR, WR_DATA,
    input  RD_DATA
  );

  modport slave (
    input  RD_EN, WR_EN, ADDR, WR_DATA,
    output RD_DATA
  );
endinterface

// File: rtl/uart_rx_mmio_fifo.sv
// Synchronous receive FIFO; pointers carry an extra wrap bit.
// A pop in the same cycle lets a full FIFO accept a push.
module uart_rx_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [7:0]               din,
  output logic [7:0]               dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wp_q, wp_d;
  logic [AW:0] rp_q, rp_d;
  logic [7:0]  mem_q [DEPTH];
  logic        do_push;
  logic        do_pop;

  assign empty = (wp_q == rp_q);
  assign full  = (wp_q[AW] != rp_q[AW]) &&
                 (wp_q[AW-1:0] == rp_q[AW-1:0]);
  assign count = wp_q - rp_q;
  assign dout  = mem_q[rp_q[AW-1:0]];

  always_comb begin
    do_pop  = pop & ~empty;
    do_push = push & (~full | do_pop);
    wp_d    = wp_q + (AW+1)'(do_push);
    rp_d    = rp_q + (AW+1)'(do_pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wp_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/uart_rx_mmio.sv
// UART receiver with DATA/STATUS/CTRL registers and UART_INT.
// Define UART_RX_PARITY_EN for 8E1 frames with a parity check.
module uart_rx_mmio
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic           CLK,
  input  logic           RESET,
  input  logic           RX,
  uart_rx_mmio_if.slave  bus,
  output logic           UART_INT
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int NW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);

  rx_state_e     state_q, state_d;
  logic [1:0]    sync_q, sync_d;
  logic [1:0]    fill_q, fill_d;
  logic          prev_q, prev_d;
  logic          armed_q, armed_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sh_q, sh_d;
  logic          oe_q, oe_d;
  logic          fe_q, fe_d;
  logic          pe_q, pe_d;
  logic          rxie_q, rxie_d;
  logic          int_q, int_d;
  logic [63:0]   rd_data_q, rd_data_d;
`ifdef UART_RX_PARITY_EN
  logic          par_err_q, par_err_d;
`endif

  logic          rx_s;
  logic          push, pop;
  logic          fe_set, pe_set;
  logic          is_data, is_stat, is_ctrl;
  logic          stat_rd;
  logic [7:0]    f_dout;
  logic          f_full, f_empty;
  logic [NW-1:0] f_count;
  logic [63:0]   status;
  logic          unused_wr;

  assign rx_s      = sync_q[1];
  assign unused_wr = ^bus.WR_DATA[63:1];

  uart_rx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (CLK),
    .rst   (RESET),
    .push  (push),
    .pop   (pop),
    .din   (sh_q),
    .dout  (f_dout),
    .full  (f_full),
    .empty (f_empty),
    .count (f_count)
  );

  // fill_q marks when sync_q[1] holds a real RX sample, not its reset value
  always_comb begin
    sync_d    = {sync_q[0], RX};
    fill_d    = {fill_q[0], 1'b1};
    prev_d    = rx_s;
    armed_d   = armed_q | (fill_q[1] & rx_s);
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    sh_d      = sh_q;
    push      = 1'b0;
    fe_set    = 1'b0;
    pe_set    = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_err_d = par_err_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (armed_q & prev_q & ~rx_s) begin
          state_d = START;
          cnt_d   = HALF;
        end
      end
      START: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else if (!rx_s) begin
          state_d = DATA;
          cnt_d   = FULL;
          bit_d   = 3'd0;
        end else begin
          state_d = IDLE;
        end
      end
      DATA: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          sh_d  = {rx_s, sh_q[7:1]};
          cnt_d = FULL;
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
      PARITY: begin
`ifdef UART_RX_PARITY_EN
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          par_err_d = ^{sh_q, rx_s};
          pe_set    = ^{sh_q, rx_s};
          cnt_d     = FULL;
          state_d   = STOP;
        end
`else
        state_d = IDLE;
`endif
      end
      STOP: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          state_d = IDLE;
          if (rx_s) begin
`ifdef UART_RX_PARITY_EN
            push = ~par_err_q;
`else
            push = 1'b1;
`endif
          end else begin
            fe_set  = 1'b1;
            armed_d = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    is_data = (bus.ADDR == UART_DATA_OFS);
    is_stat = (bus.ADDR == UART_STATUS_OFS);
    is_ctrl = (bus.ADDR == UART_CTRL_OFS);
    stat_rd = bus.RD_EN & is_stat;
    pop     = bus.RD_EN & is_data & ~f_empty;

    status            = '0;
    status[ST_NEMPTY] = ~f_empty;
    status[ST_FULL]   = f_full;
    status[ST_OE]     = oe_q;
    status[ST_FE]     = fe_q;
    status[ST_PE]     = pe_q;
    status[ST_CNT +: 5] = 5'(f_count);

    rd_data_d = rd_data_q;
    if (bus.RD_EN) begin
      unique case (1'b1)
        is_data: rd_data_d = f_empty ? 64'd0
                           : {55'd0, 1'b1, f_dout};
        is_stat: rd_data_d = status;
        is_ctrl: rd_data_d = {63'd0, rxie_q};
        default: rd_data_d = '0;
      endcase
    end

    rxie_d = (bus.WR_EN & is_ctrl) ? bus.WR_DATA[0] : rxie_q;
    // a flag raised in the same cycle as a STATUS read survives it
    oe_d   = (push & f_full & ~pop) | (oe_q & ~stat_rd);
    fe_d   = fe_set | (fe_q & ~stat_rd);
    pe_d   = pe_set | (pe_q & ~stat_rd);
    int_d  = rxie_q & (~f_empty | oe_q | fe_q | pe_q);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= IDLE;
      sync_q    <= 2'b11;
      fill_q    <= 2'b00;
      prev_q    <= 1'b1;
      armed_q   <= 1'b0;
      cnt_q     <= '0;
      bit_q     <= '0;
      sh_q      <= '0;
      oe_q      <= 1'b0;
      fe_q      <= 1'b0;
      pe_q      <= 1'b0;
      rxie_q    <= 1'b0;
      int_q     <= 1'b0;
      rd_data_q <= '0;
`ifdef UART_RX_PARITY_EN
      par_err_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      sync_q    <= sync_d;
      fill_q    <= fill_d;
      prev_q    <= prev_d;
      armed_q   <= armed_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      sh_q      <= sh_d;
      oe_q      <= oe_d;
      fe_q      <= fe_d;
      pe_q      <= pe_d;
      rxie_q    <= rxie_d;
      int_q     <= int_d;
      rd_data_q <= rd_data_d;
`ifdef UART_RX_PARITY_EN
      par_err_q <= par_err_d;
`endif
    end
  end

  assign bus.RD_DATA = rd_data_q;
  assign UART_INT    = int_q;

endmodule
